// File: rtl/mdio_link_poller_pkg.sv
// Shared MDIO definitions for the link poller: opcodes, register numbers,
// FSM state encoding, grant owner and the command payload struct.
package mdio_link_poller_pkg;

  localparam int unsigned MDIO_ADDR_W = 5;
  localparam int unsigned MDIO_DATA_W = 16;
  localparam int unsigned MDIO_OP_W   = 2;

  localparam logic [MDIO_OP_W-1:0]   MDIO_OP_WRITE    = 2'b01;
  localparam logic [MDIO_OP_W-1:0]   MDIO_OP_READ     = 2'b10;
  localparam logic [MDIO_OP_W-1:0]   MDIO_OP_READ_INC = 2'b11;

  localparam logic [MDIO_ADDR_W-1:0] MDIO_REG_BMCR = 5'd0;
  localparam logic [MDIO_ADDR_W-1:0] MDIO_REG_BMSR = 5'd1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_WR  = 3'd2,
    ST_WAIT_RD  = 3'd3,
    ST_HOST_RSP = 3'd4
  } poll_state_t;

  typedef enum logic {
    GRANT_HOST = 1'b0,
    GRANT_POLL = 1'b1
  } grant_t;

  typedef struct packed {
    logic [MDIO_ADDR_W-1:0] phy_addr;
    logic [MDIO_ADDR_W-1:0] reg_addr;
    logic [MDIO_DATA_W-1:0] data;
    logic [MDIO_OP_W-1:0]   opcode;
  } mdio_cmd_t;

  // Opcode 00 is not a legal MDIO frame type; it is issued as a write.
  function automatic logic [MDIO_OP_W-1:0] norm_opcode(input logic [MDIO_OP_W-1:0] op);
    return (op == 2'b00) ? MDIO_OP_WRITE : op;
  endfunction

endpackage

// File: rtl/mdio_poll_timer.sv
// Poll interval down-counter.
//  clk, rst_n : clock, async active-low reset
//  enable     : count while high; held at reload while low
//  expire_c   : high in the cycle the count is 0 (reload happens on that edge)
module mdio_poll_timer #(
  parameter int unsigned PERIOD = 2,
  parameter int unsigned W      = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic expire_c
);

  localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

  logic [W-1:0] count;

  assign expire_c = enable && (count == '0);

  // Countdown with reload on expiry or while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RELOAD;
    end else if (!enable || expire_c) begin
      count <= RELOAD;
    end else begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/mdio_link_poller.sv
// Arbiter/sequencer in front of one mdio_master: shares the MDIO command
// port between a host and a periodic poller that reads the status register
// of NUM_PHY PHYs and tracks their link bit.
//  host_cmd_*      : host command in (valid/ready), host_rsp_* read data out
//  m_cmd_*         : command to mdio_master, m_data_out_* read data back
//  m_busy          : mdio_master frame in progress
//  poll_enable     : enables interval timer and sweeps
//  link_up         : latest link bit per PHY, link_change: one-cycle pulse
module mdio_link_poller
  import mdio_link_poller_pkg::*;
#(
  parameter int unsigned NUM_PHY       = 4,
  parameter int unsigned PHY_ADDR_BASE = 0,
  parameter int unsigned STATUS_REG    = 1,
  parameter int unsigned LINK_BIT      = 2,
  parameter int unsigned POLL_PERIOD   = 1000000,
  parameter int unsigned PERIOD_W      = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         host_cmd_phy_addr,
  input  logic [4:0]         host_cmd_reg_addr,
  input  logic [15:0]        host_cmd_data,
  input  logic [1:0]         host_cmd_opcode,
  input  logic               host_cmd_valid,
  output logic               host_cmd_ready,
  output logic [15:0]        host_rsp_data,
  output logic               host_rsp_valid,
  input  logic               host_rsp_ready,
  output logic [4:0]         m_cmd_phy_addr,
  output logic [4:0]         m_cmd_reg_addr,
  output logic [15:0]        m_cmd_data,
  output logic [1:0]         m_cmd_opcode,
  output logic               m_cmd_valid,
  input  logic               m_cmd_ready,
  input  logic [15:0]        m_data_out,
  input  logic               m_data_out_valid,
  output logic               m_data_out_ready,
  input  logic               m_busy,
  input  logic               poll_enable,
  output logic [NUM_PHY-1:0] link_up,
  output logic               link_change
);

  localparam int unsigned    IDX_W    = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHY - 1);
  localparam logic [3:0]     LINK_SEL = 4'(LINK_BIT);

  poll_state_t        state, state_d;
  grant_t             last_grant, last_grant_d;
  grant_t             owner, owner_d;
  mdio_cmd_t          cmd, cmd_d;
  logic               poll_pending, poll_pending_d;
  logic [IDX_W-1:0]   phy_idx, phy_idx_d;
  logic               wr_skip, wr_skip_d;
  logic               host_cmd_ready_d;
  logic               m_cmd_valid_d;
  logic               m_data_out_ready_d;
  logic               host_rsp_valid_d;
  logic [15:0]        host_rsp_data_d;
  logic [NUM_PHY-1:0] link_up_d;
  logic               link_change_d;

  logic expire_c;
  logic host_req_c;
  logic poll_req_c;
  logic pick_host_c;
  logic link_new_c;

  mdio_poll_timer #(
    .PERIOD (POLL_PERIOD),
    .W      (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (poll_enable),
    .expire_c (expire_c)
  );

  assign m_cmd_phy_addr = cmd.phy_addr;
  assign m_cmd_reg_addr = cmd.reg_addr;
  assign m_cmd_data     = cmd.data;
  assign m_cmd_opcode   = cmd.opcode;

  // When both sides request, the side not granted last time wins.
  assign host_req_c  = host_cmd_valid;
  assign poll_req_c  = poll_pending && poll_enable;
  assign pick_host_c = host_req_c && (!poll_req_c || (last_grant == GRANT_POLL));
  assign link_new_c  = m_data_out[LINK_SEL];

  // Next-state and next-output logic.
  always_comb begin
    state_d            = state;
    last_grant_d       = last_grant;
    owner_d            = owner;
    cmd_d              = cmd;
    poll_pending_d     = poll_pending;
    phy_idx_d          = phy_idx;
    wr_skip_d          = 1'b0;
    host_cmd_ready_d   = 1'b0;
    m_cmd_valid_d      = m_cmd_valid;
    m_data_out_ready_d = m_data_out_ready;
    host_rsp_valid_d   = host_rsp_valid;
    host_rsp_data_d    = host_rsp_data;
    link_up_d          = link_up;
    link_change_d      = 1'b0;

    // Expiry during an unfinished sweep is dropped.
    if (expire_c && !poll_pending) begin
      poll_pending_d = 1'b1;
    end

    unique case (state)
      ST_IDLE: begin
        if (pick_host_c) begin
          host_cmd_ready_d = 1'b1;
          cmd_d.phy_addr   = host_cmd_phy_addr;
          cmd_d.reg_addr   = host_cmd_reg_addr;
          cmd_d.data       = host_cmd_data;
          cmd_d.opcode     = norm_opcode(host_cmd_opcode);
          owner_d          = GRANT_HOST;
          last_grant_d     = GRANT_HOST;
          m_cmd_valid_d    = 1'b1;
          state_d          = ST_ISSUE;
        end else if (poll_req_c) begin
          cmd_d.phy_addr   = 5'(PHY_ADDR_BASE) + 5'(phy_idx);
          cmd_d.reg_addr   = 5'(STATUS_REG);
          cmd_d.data       = 16'h0000;
          cmd_d.opcode     = MDIO_OP_READ;
          owner_d          = GRANT_POLL;
          last_grant_d     = GRANT_POLL;
          m_cmd_valid_d    = 1'b1;
          state_d          = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (m_cmd_ready) begin
          m_cmd_valid_d = 1'b0;
          if (cmd.opcode[1]) begin
            m_data_out_ready_d = 1'b1;
            state_d            = ST_WAIT_RD;
          end else begin
            wr_skip_d = 1'b1;
            state_d   = ST_WAIT_WR;
          end
        end
      end

      // m_busy may not yet be high in the first cycle after the handshake.
      ST_WAIT_WR: begin
        if (!wr_skip && !m_busy) begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_RD: begin
        if (m_data_out_valid) begin
          m_data_out_ready_d = 1'b0;
          if (owner == GRANT_HOST) begin
            host_rsp_data_d  = m_data_out;
            host_rsp_valid_d = 1'b1;
            state_d          = ST_HOST_RSP;
          end else begin
            if (link_new_c != link_up[phy_idx]) begin
              link_up_d[phy_idx] = link_new_c;
              link_change_d      = 1'b1;
            end
            if (phy_idx == LAST_IDX) begin
              phy_idx_d      = '0;
              poll_pending_d = 1'b0;
            end else begin
              phy_idx_d = phy_idx + IDX_W'(1);
            end
            state_d = ST_IDLE;
          end
        end
      end

      ST_HOST_RSP: begin
        if (host_rsp_ready) begin
          host_rsp_valid_d = 1'b0;
          state_d          = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      last_grant       <= GRANT_POLL;
      owner            <= GRANT_POLL;
      cmd              <= '0;
      poll_pending     <= 1'b0;
      phy_idx          <= '0;
      wr_skip          <= 1'b0;
      host_cmd_ready   <= 1'b0;
      m_cmd_valid      <= 1'b0;
      m_data_out_ready <= 1'b0;
      host_rsp_valid   <= 1'b0;
      host_rsp_data    <= '0;
      link_up          <= '0;
      link_change      <= 1'b0;
    end else begin
      state            <= state_d;
      last_grant       <= last_grant_d;
      owner            <= owner_d;
      cmd              <= cmd_d;
      poll_pending     <= poll_pending_d;
      phy_idx          <= phy_idx_d;
      wr_skip          <= wr_skip_d;
      host_cmd_ready   <= host_cmd_ready_d;
      m_cmd_valid      <= m_cmd_valid_d;
      m_data_out_ready <= m_data_out_ready_d;
      host_rsp_valid   <= host_rsp_valid_d;
      host_rsp_data    <= host_rsp_data_d;
      link_up          <= link_up_d;
      link_change      <= link_change_d;
    end
  end

endmodule
